// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and tracker state encoding, common to the
// sync-pulse generator and the sync decoder.
package vga_timing_pkg;

  localparam int DEF_TOTAL_COLS  = 800;
  localparam int DEF_TOTAL_ROWS  = 525;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int CNT_W           = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } sync_state_t;

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] last);
    return (v == last) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// One-cycle delay of a sync line plus a strobe on its rising edge.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sync,
  output logic o_sync_d,
  output logic o_rise
);

  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= 1'b0;
    else       r_sync <= i_sync;
  end

  assign o_sync_d = r_sync;
  assign o_rise   = i_sync & ~r_sync;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers column/row position, frame-start, active area and lock status
// from a pair of VGA sync lines.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_H_Sync,
  input  logic             i_V_Sync,
  output logic             o_H_Sync,
  output logic             o_V_Sync,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Frame_Start,
  output logic             o_Active,
  output logic             o_Locked
);

  if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024 || LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_bad_param
    $error("vga_sync_decoder: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W:0]   A_COLS = (CNT_W+1)'(ACTIVE_COLS);
  localparam logic [CNT_W:0]   A_ROWS = (CNT_W+1)'(ACTIVE_ROWS);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [10:0]      WD_LAST = 11'(2 * TOTAL_ROWS - 1);

  logic w_h_rise, w_v_rise, w_col_last, w_row_last;
  sync_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_col, r_row, w_col_nxt, w_row_nxt;
  logic [3:0]  r_lock, w_lock_nxt;
  logic [10:0] r_wd, w_wd_nxt;
  logic        r_seen, w_seen_nxt, w_fs_nxt, r_fs, r_locked;

  sync_edge_detect u_h_edge (.i_clk(CLK), .i_rst(RST), .i_sync(i_H_Sync),
                             .o_sync_d(o_H_Sync), .o_rise(w_h_rise));
  sync_edge_detect u_v_edge (.i_clk(CLK), .i_rst(RST), .i_sync(i_V_Sync),
                             .o_sync_d(o_V_Sync), .o_rise(w_v_rise));

  assign w_col_last = (r_col == C_LAST);
  assign w_row_last = (r_row == R_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_lock_nxt  = r_lock;
    w_seen_nxt  = r_seen;
    w_wd_nxt    = r_wd;
    w_fs_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        w_col_nxt = '0;
        w_row_nxt = '0;
        w_wd_nxt  = '0;
        if (w_v_rise) begin
          w_fs_nxt    = 1'b1;
          w_seen_nxt  = 1'b1;
          w_state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (w_v_rise) begin
          // Frame edge wins over a coincident line edge
          w_col_nxt = '0;
          w_row_nxt = '0;
          w_fs_nxt  = 1'b1;
          w_wd_nxt  = '0;
          if (r_seen && w_col_last && w_row_last)
            w_lock_nxt = (r_lock == LOCK_N) ? r_lock : r_lock + 4'd1;
          else
            w_lock_nxt = '0;
        end else if (w_h_rise || w_col_last) begin
          w_col_nxt = '0;
          w_row_nxt = wrap_inc(r_row, R_LAST);
          if (w_h_rise && !w_col_last) w_lock_nxt = '0;
          // Line watchdog: no frame edge for two full frames of lines
          if (r_wd == WD_LAST) begin
            w_state_nxt = IDLE;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
            w_lock_nxt  = '0;
            w_wd_nxt    = '0;
          end else begin
            w_wd_nxt = r_wd + 11'd1;
          end
        end else begin
          w_col_nxt = r_col + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_lock   <= '0;
      r_seen   <= 1'b0;
      r_wd     <= '0;
      r_fs     <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_col    <= w_col_nxt;
      r_row    <= w_row_nxt;
      r_lock   <= w_lock_nxt;
      r_seen   <= w_seen_nxt;
      r_wd     <= w_wd_nxt;
      r_fs     <= w_fs_nxt;
      r_locked <= (w_lock_nxt == LOCK_N);
    end
  end

  assign o_Col_Count   = r_col;
  assign o_Row_Count   = r_row;
  assign o_Frame_Start = r_fs;
  assign o_Locked      = r_locked;
  assign o_Active      = r_locked && ({1'b0, r_col} < A_COLS) && ({1'b0, r_row} < A_ROWS);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: a behavioural sync source with adjustable line/frame length
// drives two decoder instances (20x12 lock-2 and 10x6 lock-1).
module tb_vga_sync_decoder;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic h_sync = 1'b0, v_sync = 1'b0;

  logic       a_h, a_v, a_fs, a_act, a_locked;
  logic [9:0] a_col, a_row;
  logic       b_h, b_v, b_fs, b_act, b_locked;
  logic [9:0] b_col, b_row;

  int checks = 0;
  int errors = 0;
  int sc, sr, tc, tr, ac, ar;
  bit vhold = 1'b0;
  int wd_n;

  always #5 CLK = ~CLK;

  vga_sync_decoder #(.TOTAL_COLS(20), .TOTAL_ROWS(12), .ACTIVE_COLS(16),
                     .ACTIVE_ROWS(8), .LOCK_FRAMES(2)) dut_a (
    .CLK(CLK), .RST(RST), .i_H_Sync(h_sync), .i_V_Sync(v_sync),
    .o_H_Sync(a_h), .o_V_Sync(a_v), .o_Col_Count(a_col), .o_Row_Count(a_row),
    .o_Frame_Start(a_fs), .o_Active(a_act), .o_Locked(a_locked));

  vga_sync_decoder #(.TOTAL_COLS(10), .TOTAL_ROWS(6), .ACTIVE_COLS(8),
                     .ACTIVE_ROWS(4), .LOCK_FRAMES(1)) dut_b (
    .CLK(CLK), .RST(RST), .i_H_Sync(h_sync), .i_V_Sync(v_sync),
    .o_H_Sync(b_h), .o_V_Sync(b_v), .o_Col_Count(b_col), .o_Row_Count(b_row),
    .o_Frame_Start(b_fs), .o_Active(b_act), .o_Locked(b_locked));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    h_sync = (sc < ac);
    v_sync = vhold ? 1'b0 : (sr < ar);
  endtask

  // Advance the source one pixel, apply it, clock, and settle past the edge
  task automatic step();
    sc++;
    if (sc >= tc) begin
      sc = 0;
      sr++;
      if (sr >= tr) sr = 0;
    end
    drive();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_to(input int c, input int r, input string tag);
    for (int n = 0; n < 1500; n++) begin
      if (sc == c && sr == r) break;
      step();
    end
    chk({tag, "_reached"}, (sc == c && sr == r), 1);
  endtask

  task automatic wait_fs(input bit use_b, input string tag);
    bit found = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      step();
      if (use_b ? b_fs : a_fs) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_fs_seen"}, found, 1);
  endtask

  initial begin
    tc = 20; tr = 12; ac = 16; ar = 8;
    sc = 5;  sr = 9;
    drive();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_col", a_col, 0);
    chk("rst_row", a_row, 0);
    chk("rst_fs", a_fs, 0);
    chk("rst_locked", a_locked, 0);
    chk("rst_hv", {a_h, a_v, a_act}, 0);
    RST = 1'b0;

    step();
    chk("idle_col", a_col, 0);
    chk("hsync_delay", a_h, 1);

    wait_fs(1'b0, "acq1");
    chk("acq1_counts", {a_col, a_row}, 0);
    chk("acq1_locked", a_locked, 0);
    chk("acq1_vsync", a_v, 1);
    wait_fs(1'b0, "acq2");
    chk("acq2_locked", a_locked, 0);
    wait_fs(1'b0, "acq3");
    chk("acq3_locked", a_locked, 1);

    run_to(15, 7, "act_in");
    chk("act_in_col", a_col, 15);
    chk("act_in_row", a_row, 7);
    chk("act_in", a_act, 1);
    step();
    chk("act_out_col", a_col, 16);
    chk("act_out", a_act, 0);
    run_to(0, 8, "wrap");
    chk("wrap_counts", {a_col, a_row}, {10'd0, 10'd8});

    // One line of 19 columns
    run_to(0, 2, "short_pre");
    tc = 19;
    run_to(18, 2, "short_end");
    chk("short_pre_locked", a_locked, 1);
    step();
    tc = 20;
    chk("short_locked", a_locked, 0);
    chk("short_col", a_col, 0);
    chk("short_row", a_row, 3);
    wait_fs(1'b0, "short_r1");
    chk("short_r1_locked", a_locked, 0);
    wait_fs(1'b0, "short_r2");
    chk("short_r2_locked", a_locked, 1);

    // One frame of 11 rows
    run_to(0, 5, "sframe_pre");
    tr = 11;
    wait_fs(1'b0, "sframe");
    tr = 12;
    chk("sframe_locked", a_locked, 0);
    chk("sframe_counts", {a_col, a_row}, 0);
    wait_fs(1'b0, "sframe_r1");
    wait_fs(1'b0, "sframe_r2");
    chk("sframe_r2_locked", a_locked, 1);

    // Asynchronous reset mid-frame
    run_to(10, 5, "arst_pre");
    chk("arst_pre_locked", a_locked, 1);
    RST = 1'b1;
    #1;
    chk("arst_outs", {a_col, a_row, a_fs, a_locked, a_act, a_h, a_v}, 0);
    run_to(0, 8, "arst_hold");
    RST = 1'b0;
    repeat (3) step();
    chk("arst_idle_counts", {a_col, a_row}, 0);
    chk("arst_idle_locked", a_locked, 0);
    wait_fs(1'b0, "arst_r0");
    chk("arst_r0_locked", a_locked, 0);
    wait_fs(1'b0, "arst_r1");
    wait_fs(1'b0, "arst_r2");
    chk("arst_r2_locked", a_locked, 1);

    // Frame sync vanishes: 24 lines to the watchdog
    vhold = 1'b1;
    wd_n = 0;
    for (int n = 1; n <= 600; n++) begin
      step();
      if (!a_locked) begin
        wd_n = n;
        break;
      end
    end
    chk("wd_cycles", wd_n, 480);
    chk("wd_counts", {a_col, a_row}, 0);
    step();
    chk("wd_idle_col", a_col, 0);
    run_to(0, 8, "wd_release");
    vhold = 1'b0;
    wait_fs(1'b0, "wd_reacq");
    chk("wd_reacq_locked", a_locked, 0);

    // Small timing on the second instance
    RST = 1'b1;
    tc = 10; tr = 6; ac = 8; ar = 4;
    sc = 3; sr = 5;
    drive();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    wait_fs(1'b1, "b_acq1");
    chk("b_acq1_locked", b_locked, 0);
    wait_fs(1'b1, "b_acq2");
    chk("b_acq2_locked", b_locked, 1);
    run_to(9, 1, "b_colwrap");
    chk("b_col9", {b_col, b_row}, {10'd9, 10'd1});
    step();
    chk("b_col0", {b_col, b_row}, {10'd0, 10'd2});
    run_to(7, 3, "b_act");
    chk("b_act_in", b_act, 1);
    step();
    chk("b_act_out", b_act, 0);
    run_to(9, 5, "b_rowwrap");
    chk("b_row5", b_row, 5);
    step();
    chk("b_rowwrap_fs", b_fs, 1);
    chk("b_rowwrap_counts", {b_col, b_row}, 0);
    chk("b_rowwrap_locked", b_locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
